mem_lsu: RTL and testbench
==========================

Name: mem_lsu

Overview:
Load/store initiator for the byte-addressable `mem` block: the requester that drives `mem`'s address, write-data, write-enable and mode inputs, and captures its read data.
- Accepts one RISC-V-style load/store per transaction from the core over a valid/ready handshake.
- Translates funct3 into `mem` mode codes and bounds-checks the access.
- Returns the result over a valid/ready response channel.
- Sits between the core datapath and `mem`.

Parameters:
- MEM_BYTES, 256, size of the attached memory in bytes; accesses must lie fully inside [0, MEM_BYTES-1].
- AW, 32, address width on both core and memory sides.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous and active-low.
- req_valid  in  1  core request valid.
- req_ready  out  1  LSU can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3 (loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores: 000 SB, 001 SH, 010 SW).
- req_addr  in  AW  byte address.
- req_wdata  in  32  store data; right-justified for SB/SH.
- resp_valid  out  1  response valid.
- resp_ready  in  1  core accepts the response.
- resp_rdata  out  32  load result, extended by `mem`; 0 for stores and errors.
- resp_err  out  1  access rejected (illegal funct3, out of range, misaligned when trapping).
- mem_a  out  AW  memory address.
- mem_wd  out  32  memory write data.
- mem_we  out  1  memory write enable.
- mem_mode  out  3  memory mode: 000 word, 001 half zero-extended, 101 half sign-extended, 010 byte zero-extended, 110 byte sign-extended.
- mem_rd  in  32  memory read data.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - State returns to IDLE.
  - req_ready=0 while reset_n=0, and 1 in the first IDLE cycle afterwards.
  - resp_valid=0, resp_rdata=0, resp_err=0.
  - mem_a=0, mem_wd=0, mem_we=0, mem_mode=000.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: req_ready=1. When req_valid&&req_ready, latch we/funct3/addr/wdata and decode.
    - Decode legal and in range -> ISSUE.
    - Decode illegal -> RESP with err=1 and no memory access.
  - ISSUE (1 cycle): drive mem_a=addr and mem_mode=decoded mode; mem_wd=wdata; mem_we=we.
    - A store commits at the closing clk edge.
    - Next state is WAIT.
  - WAIT (1 cycle): mem_we=0; mem_a and mem_mode held. mem_rd is registered in `mem` at the ISSUE edge; sample it into resp_rdata at the end of WAIT (loads only). -> RESP.
  - RESP: resp_valid=1. Hold resp_rdata and resp_err stable until resp_valid&&resp_ready, then -> IDLE.
- req_ready=0 in every state other than IDLE.
- Latency: request accepted at edge T; resp_valid is high from T+3 (T+1 for decode errors).
- Decode rules:
  - Load funct3 011/110/111 are illegal.
  - Store funct3 with bit2 set, or equal to 011, is illegal.
  - Size: byte=1, half=2, word=4.
  - Out of range when addr+size > MEM_BYTES. The sum is computed AW+1 bits wide so there is no wrap-around (e.g. addr 0xFFFFFFFF is rejected).
- mem_we is never asserted for an erroring request.
- Memory is big-endian: the byte at addr is the most significant byte.
- Outside ISSUE/WAIT: mem_we=0, mem_mode=000, mem_a holds its last value.
- Reset mid-operation: asserting reset_n=0 while in ISSUE drops mem_we immediately. The store may be lost; this is acceptable.

Optional Feature:
- Macro: MEM_LSU_MISALIGN_TRAP_EN.
- Defined: a half access with addr[0]!=0, or a word access with addr[1:0]!=0, gives resp_err=1 with no memory access (latency T+1).
- Undefined: misaligned accesses pass through to `mem`, which handles arbitrary byte addresses; only the range check applies.

Decomposition:
- mem_pkg:
  - mem mode constants (MODE_W=000, MODE_HU=001, MODE_HS=101, MODE_BU=010, MODE_BS=110).
  - funct3 constants.
  - lsu state encoding.
  - size constants.
- One sub-module, mem_lsu_decode: combinational funct3/we/addr -> mode, size, illegal, oor, misaligned. The FSM stays in mem_lsu.

Test Plan:
- SW 0xDEADBEEF @0x10, then LW @0x10 -> resp_rdata 0xDEADBEEF, resp_err=0, resp_valid 3 cycles after acceptance.
- After the SW above:
  - LB @0x10 -> 0xFFFFFFDE
  - LBU @0x11 -> 0x000000AD
  - LH @0x12 -> 0xFFFFBEEF
  - LHU @0x12 -> 0x0000BEEF
- LW @0xFD (MEM_BYTES=256) -> resp_err=1, resp_rdata=0, mem_we never high. Load funct3 011 -> resp_err=1 after 1 cycle.
- Misaligned LW @0x11 after the SW:
  - MEM_LSU_MISALIGN_TRAP_EN defined -> err=1.
  - Undefined -> 0xADBEEF00.
- Backpressure: resp_ready=0 for 3 cycles in RESP -> resp_valid, resp_rdata and resp_err stable; req_ready=0; a new req_valid is not accepted until the handshake completes.
- Reset pulse during ISSUE of a SB -> all outputs at reset values asynchronously; req_ready=1 in the first IDLE cycle after release.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared constants for the mem load/store unit: mem mode codes, RISC-V funct3
// codes, access sizes and the LSU state encoding.
package mem_pkg;

    localparam logic [2:0] MODE_W  = 3'b000;
    localparam logic [2:0] MODE_HU = 3'b001;
    localparam logic [2:0] MODE_HS = 3'b101;
    localparam logic [2:0] MODE_BU = 3'b010;
    localparam logic [2:0] MODE_BS = 3'b110;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [2:0] SIZE_B = 3'd1;
    localparam logic [2:0] SIZE_H = 3'd2;
    localparam logic [2:0] SIZE_W = 3'd4;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } lsu_state_e;

endpackage

// File: rtl/mem_lsu_decode.sv
// Combinational request decode: funct3/we/addr -> mem mode, illegal, out-of-range, misaligned.
// MEM_LSU_MISALIGN_TRAP_EN enables the misalignment flag; otherwise it is tied low.
module mem_lsu_decode
    import mem_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 256,
    parameter int unsigned AW        = 32
) (
    input  logic          we,
    input  logic [2:0]    funct3,
    input  logic [AW-1:0] addr,
    output logic [2:0]    mode,
    output logic          illegal,
    output logic          oor,
    output logic          misaligned
);

    localparam logic [AW:0] LIMIT = (AW + 1)'(MEM_BYTES);

    logic [2:0]  size;
    logic [AW:0] end_addr;

    always_comb begin
        mode    = MODE_W;
        size    = SIZE_W;
        illegal = 1'b0;
        case (funct3)
            F3_B: begin
                mode = we ? MODE_BU : MODE_BS;
                size = SIZE_B;
            end
            F3_H: begin
                mode = we ? MODE_HU : MODE_HS;
                size = SIZE_H;
            end
            F3_W: begin
                mode = MODE_W;
                size = SIZE_W;
            end
            F3_BU: begin
                mode    = MODE_BU;
                size    = SIZE_B;
                illegal = we;
            end
            F3_HU: begin
                mode    = MODE_HU;
                size    = SIZE_H;
                illegal = we;
            end
            default: illegal = 1'b1;
        endcase
    end

    // One extra bit so addresses near the top of the space cannot wrap into range.
    assign end_addr = {1'b0, addr} + {{(AW - 2){1'b0}}, size};
    assign oor      = end_addr > LIMIT;

`ifdef MEM_LSU_MISALIGN_TRAP_EN
    assign misaligned = ((size == SIZE_H) && addr[0]) ||
                        ((size == SIZE_W) && (addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

endmodule

// File: rtl/mem_lsu.sv
// Load/store initiator for the byte-addressable mem block: accepts one request,
// issues it to mem, and returns the result. Misalignment trapping: MEM_LSU_MISALIGN_TRAP_EN.
module mem_lsu
    import mem_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 256,
    parameter int unsigned AW        = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [2:0]    req_funct3,
    input  logic [AW-1:0] req_addr,
    input  logic [31:0]   req_wdata,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [31:0]   resp_rdata,
    output logic          resp_err,
    output logic [AW-1:0] mem_a,
    output logic [31:0]   mem_wd,
    output logic          mem_we,
    output logic [2:0]    mem_mode,
    input  logic [31:0]   mem_rd
);

    lsu_state_e    state_q, state_d;
    logic          we_q;
    logic [2:0]    mode_q;
    logic [AW-1:0] mem_a_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rdata_q;
    logic          err_q;

    logic [2:0] dec_mode;
    logic       dec_illegal;
    logic       dec_oor;
    logic       dec_misaligned;
    logic       dec_err;
    logic       accept;

    mem_lsu_decode #(
        .MEM_BYTES (MEM_BYTES),
        .AW        (AW)
    ) u_decode (
        .we         (req_we),
        .funct3     (req_funct3),
        .addr       (req_addr),
        .mode       (dec_mode),
        .illegal    (dec_illegal),
        .oor        (dec_oor),
        .misaligned (dec_misaligned)
    );

    assign dec_err = dec_illegal | dec_oor | dec_misaligned;
    assign accept  = (state_q == StIdle) && req_valid;

    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_we     = 1'b0;
        mem_mode   = MODE_W;
        case (state_q)
            StIdle: begin
                req_ready = reset_n;
                if (req_valid) begin
                    state_d = dec_err ? StResp : StIssue;
                end
            end
            StIssue: begin
                mem_we   = we_q;
                mem_mode = mode_q;
                state_d  = StWait;
            end
            StWait: begin
                mem_mode = mode_q;
                state_d  = StResp;
            end
            StResp: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            we_q    <= 1'b0;
            mode_q  <= MODE_W;
            mem_a_q <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q    <= req_we;
                mode_q  <= dec_mode;
                rdata_q <= '0;
                err_q   <= dec_err;
                // Rejected requests leave the memory-side address and data untouched.
                if (!dec_err) begin
                    mem_a_q <= req_addr;
                    wdata_q <= req_wdata;
                end
            end
            if ((state_q == StWait) && !we_q) begin
                rdata_q <= mem_rd;
            end
        end
    end

    assign mem_a      = mem_a_q;
    assign mem_wd     = wdata_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: a big-endian byte memory stands in for mem,
// and a byte-array reference model predicts every response.
module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic [2:0]  mem_mode;
    logic [31:0] mem_rd = 32'd0;

    int n_cmp = 0;
    int n_bad = 0;
    int we_cnt = 0;

    logic [7:0] stub [256] = '{default: 8'h00};
    logic [7:0] ref_mem [256] = '{default: 8'h00};

    always #5 clk = ~clk;

    mem_lsu #(
        .MEM_BYTES (256),
        .AW        (32)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_a      (mem_a),
        .mem_wd     (mem_wd),
        .mem_we     (mem_we),
        .mem_mode   (mem_mode),
        .mem_rd     (mem_rd)
    );

    // Stand-in for mem: big-endian bytes, registered read, extension per mode.
    function automatic int stub_size(input logic [2:0] m);
        case (m[1:0])
            2'b00:   return 4;
            2'b01:   return 2;
            default: return 1;
        endcase
    endfunction

    function automatic logic [31:0] stub_read(input logic [31:0] a, input logic [2:0] m);
        logic [31:0] v = 32'd0;
        int sz = stub_size(m);
        for (int i = 0; i < sz; i++) v = (v << 8) | 32'(stub[8'(a[7:0] + 8'(i))]);
        if (m[2] && sz == 1) v = {{24{v[7]}}, v[7:0]};
        if (m[2] && sz == 2) v = {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    always @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < stub_size(mem_mode); i++)
                stub[8'(mem_a[7:0] + 8'(i))] <= 8'(mem_wd >> (8 * (stub_size(mem_mode) - 1 - i)));
            we_cnt <= we_cnt + 1;
        end
        mem_rd <= stub_read(mem_a, mem_mode);
    end

    // Reference model: RISC-V access semantics on a flat byte array.
    task automatic model_access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, output logic [31:0] rd,
                                output logic er, output int lat);
        int sz = 4;
        bit sgn = 0;
        bit ok = 1;
        longint v = 0;
        case (f3)
            3'd0: begin sz = 1; sgn = !we; end
            3'd1: begin sz = 2; sgn = !we; end
            3'd2: sz = 4;
            3'd4: begin sz = 1; ok = !we; end
            3'd5: begin sz = 2; ok = !we; end
            default: ok = 0;
        endcase
        if (longint'(a) + longint'(sz) > 256) ok = 0;
`ifdef MEM_LSU_MISALIGN_TRAP_EN
        if (longint'(a) % longint'(sz) != 0) ok = 0;
`endif
        er  = !ok;
        rd  = 32'd0;
        lat = ok ? 3 : 1;
        if (ok && we) begin
            for (int i = 0; i < sz; i++) ref_mem[8'(a[7:0] + 8'(i))] = 8'(wd >> (8 * (sz - 1 - i)));
        end else if (ok) begin
            for (int i = 0; i < sz; i++) v = v * 256 + longint'(ref_mem[8'(a[7:0] + 8'(i))]);
            if (sgn && v >= (longint'(1) << (8 * sz - 1))) v = v - (longint'(1) << (8 * sz));
            rd = 32'(v);
        end
    endtask

    // Issue one request with resp_ready high; returns result and cycles to resp_valid.
    task automatic drive_txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, output logic [31:0] rd,
                             output logic er, output int lat);
        int n = 0;
        req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
        while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        rd = resp_rdata;
        er = resp_err;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL rst req_ready got %b want 0", req_ready); end
        n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL rst resp_valid got %b want 0", resp_valid); end
        n_cmp++; if (resp_rdata !== 32'd0) begin n_bad++; $display("FAIL rst resp_rdata got %h want 0", resp_rdata); end
        n_cmp++; if (resp_err !== 1'b0) begin n_bad++; $display("FAIL rst resp_err got %b want 0", resp_err); end
        n_cmp++; if (mem_a !== 32'd0) begin n_bad++; $display("FAIL rst mem_a got %h want 0", mem_a); end
        n_cmp++; if (mem_wd !== 32'd0) begin n_bad++; $display("FAIL rst mem_wd got %h want 0", mem_wd); end
        n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL rst mem_we got %b want 0", mem_we); end
        n_cmp++; if (mem_mode !== 3'b000) begin n_bad++; $display("FAIL rst mem_mode got %b want 000", mem_mode); end
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_release req_ready got %b want 1", req_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_store_load();
        logic [31:0] rd, erd; logic er, eer; int lat, elat;
        model_access(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, erd, eer, elat);
        drive_txn(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, er, lat);
        n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL sw err got %b want 0", er); end
        n_cmp++; if (lat != 3) begin n_bad++; $display("FAIL sw latency got %0d want 3", lat); end
        drive_txn(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
        n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL lw rdata got %h want deadbeef", rd); end
        n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL lw err got %b want 0", er); end
        n_cmp++; if (lat != 3) begin n_bad++; $display("FAIL lw latency got %0d want 3", lat); end
    endtask

    task automatic test_load_ext();
        logic [2:0]  f3s [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] ads [4] = '{32'h10, 32'h11, 32'h12, 32'h12};
        logic [31:0] exp [4] = '{32'hFFFFFFDE, 32'h000000AD, 32'hFFFFBEEF, 32'h0000BEEF};
        logic [31:0] rd; logic er; int lat;
        for (int i = 0; i < 4; i++) begin
            drive_txn(1'b0, f3s[i], ads[i], 32'h0, rd, er, lat);
            n_cmp++; if (rd !== exp[i]) begin n_bad++; $display("FAIL ext[%0d] rdata got %h want %h", i, rd, exp[i]); end
            n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL ext[%0d] err got %b want 0", i, er); end
        end
    endtask

    task automatic test_errors();
        logic        wes [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [2:0]  f3s [4] = '{3'b010, 3'b011, 3'b100, 3'b000};
        logic [31:0] ads [4] = '{32'hFD, 32'h20, 32'h20, 32'hFFFFFFFF};
        logic [31:0] rd; logic er; int lat;
        int we_before;
        for (int i = 0; i < 4; i++) begin
            we_before = we_cnt;
            drive_txn(wes[i], f3s[i], ads[i], 32'hCAFEF00D, rd, er, lat);
            n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL err[%0d] err got %b want 1", i, er); end
            n_cmp++; if (rd !== 32'd0) begin n_bad++; $display("FAIL err[%0d] rdata got %h want 0", i, rd); end
            n_cmp++; if (lat != 1) begin n_bad++; $display("FAIL err[%0d] latency got %0d want 1", i, lat); end
            n_cmp++; if (we_cnt != we_before) begin n_bad++; $display("FAIL err[%0d] mem_we cycles got %0d want 0", i, we_cnt - we_before); end
        end
    endtask

    task automatic test_misalign();
        logic [31:0] rd; logic er; int lat;
        drive_txn(1'b0, 3'b010, 32'h11, 32'h0, rd, er, lat);
`ifdef MEM_LSU_MISALIGN_TRAP_EN
        n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL misalign err got %b want 1", er); end
        n_cmp++; if (lat != 1) begin n_bad++; $display("FAIL misalign latency got %0d want 1", lat); end
`else
        n_cmp++; if (rd !== 32'hADBEEF00) begin n_bad++; $display("FAIL misalign rdata got %h want adbeef00", rd); end
        n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL misalign err got %b want 0", er); end
`endif
    endtask

    task automatic test_backpressure();
        int lat = 0;
        resp_ready = 1'b0;
        req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        while (!resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        // A second request waits while the first response is stalled.
        req_we = 1'b0; req_funct3 = 3'b100; req_addr = 32'h11; req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_cmp++; if (resp_valid !== 1'b1) begin n_bad++; $display("FAIL bp[%0d] resp_valid got %b want 1", i, resp_valid); end
            n_cmp++; if (resp_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL bp[%0d] rdata got %h want deadbeef", i, resp_rdata); end
            n_cmp++; if (resp_err !== 1'b0) begin n_bad++; $display("FAIL bp[%0d] err got %b want 0", i, resp_err); end
            n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL bp[%0d] req_ready got %b want 0", i, req_ready); end
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL bp_done resp_valid got %b want 0", resp_valid); end
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL bp_done req_ready got %b want 1", req_ready); end
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        n_cmp++; if (resp_rdata !== 32'h000000AD) begin n_bad++; $display("FAIL bp_next rdata got %h want 000000ad", resp_rdata); end
        n_cmp++; if (lat != 3) begin n_bad++; $display("FAIL bp_next latency got %0d want 3", lat); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h20; req_wdata = 32'h12345655;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n_cmp++; if (mem_we !== 1'b1) begin n_bad++; $display("FAIL issue mem_we got %b want 1", mem_we); end
        n_cmp++; if (mem_a !== 32'h20) begin n_bad++; $display("FAIL issue mem_a got %h want 20", mem_a); end
        n_cmp++; if (mem_wd !== 32'h12345655) begin n_bad++; $display("FAIL issue mem_wd got %h want 12345655", mem_wd); end
        n_cmp++; if (mem_mode[1:0] !== 2'b10) begin n_bad++; $display("FAIL issue mem_mode got %b want x10", mem_mode); end
        #2 reset_n = 1'b0;
        #1;
        n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL midrst mem_we got %b want 0", mem_we); end
        n_cmp++; if (mem_a !== 32'd0) begin n_bad++; $display("FAIL midrst mem_a got %h want 0", mem_a); end
        n_cmp++; if (mem_wd !== 32'd0) begin n_bad++; $display("FAIL midrst mem_wd got %h want 0", mem_wd); end
        n_cmp++; if (mem_mode !== 3'b000) begin n_bad++; $display("FAIL midrst mem_mode got %b want 000", mem_mode); end
        n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL midrst req_ready got %b want 0", req_ready); end
        n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL midrst resp_valid got %b want 0", resp_valid); end
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_release req_ready got %b want 1", req_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [31:0] rd, erd, a, wd; logic er, eer, we; logic [2:0] f3; int lat, elat, r;
        for (int i = 0; i < 60; i++) begin
            r  = int'($urandom_range(0, 9));
            if (r < 6)      a = 32'($urandom_range(0, 40));
            else if (r < 9) a = 32'($urandom_range(248, 255));
            else            a = $urandom;
            f3 = 3'($urandom_range(0, 7));
            we = 1'($urandom_range(0, 1));
            wd = $urandom;
            model_access(we, f3, a, wd, erd, eer, elat);
            drive_txn(we, f3, a, wd, rd, er, lat);
            n_cmp++; if (er !== eer) begin n_bad++; $display("FAIL rand[%0d] err got %b want %b", i, er, eer); end
            n_cmp++; if (rd !== erd) begin n_bad++; $display("FAIL rand[%0d] rdata got %h want %h", i, rd, erd); end
            n_cmp++; if (lat != elat) begin n_bad++; $display("FAIL rand[%0d] latency got %0d want %0d", i, lat, elat); end
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_load_ext();
        test_errors();
        test_misalign();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
